// File: rtl/adam_axil_pkg.sv
// Shared AXI-Lite definitions for the adam fabric: response codes and the response type.
package adam_axil_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

endpackage

// File: rtl/adam_axil_if.sv
// AXI-Lite channel bundle used between the fabric memory masters and their slaves.
interface AXI_LITE #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    import adam_axil_pkg::*;

    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;
    resp_t                   b_resp;
    logic                    b_valid;
    logic                    b_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    resp_t                   r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport Slave (
        input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
        input  ar_addr, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );

    modport Master (
        output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
        output ar_addr, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );

endinterface

// File: rtl/adam_axil_sram_bridge.sv
// AXI-Lite slave to single-port synchronous SRAM bridge, one transaction in flight,
// with pause support so the fabric can quiesce the memory.
module adam_axil_sram_bridge
    import adam_axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SIZE           = 4096,
    parameter int unsigned MEM_ADDR_WIDTH = $clog2(SIZE / (DATA_WIDTH / 8))
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pause_req,
    output logic                      pause_ack,
    AXI_LITE.Slave                    axil,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH/8-1:0]   mem_be,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int unsigned          STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned          OFFSET     = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH:0]  SIZE_EXT   = (ADDR_WIDTH + 1)'(SIZE);

    localparam logic [2:0] ST_PAUSED = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_MEM_WR = 3'd2;
    localparam logic [2:0] ST_MEM_RD = 3'd3;
    localparam logic [2:0] ST_RD_CAP = 3'd4;
    localparam logic [2:0] ST_B_RESP = 3'd5;
    localparam logic [2:0] ST_R_RESP = 3'd6;

    logic [2:0]            state;
    logic                  rr_write;
    logic                  in_range_q;
    resp_t                 b_resp_q;
    resp_t                 r_resp_q;
    logic [DATA_WIDTH-1:0] r_data_q;

    logic wr_elig;
    logic rd_elig;
    logic wr_grant;
    logic rd_grant;
    logic wr_in_range;
    logic rd_in_range;

    // Writes need AW and W together; on a conflict the round-robin flag decides.
    assign wr_elig  = (state == ST_IDLE) && !pause_req && axil.aw_valid && axil.w_valid;
    assign rd_elig  = (state == ST_IDLE) && !pause_req && axil.ar_valid;
    assign wr_grant = wr_elig && (!rd_elig || rr_write);
    assign rd_grant = rd_elig && !wr_grant;

    assign wr_in_range = {1'b0, axil.aw_addr} < SIZE_EXT;
    assign rd_in_range = {1'b0, axil.ar_addr} < SIZE_EXT;

    assign axil.aw_ready = wr_grant;
    assign axil.w_ready  = wr_grant;
    assign axil.ar_ready = rd_grant;
    assign axil.b_valid  = (state == ST_B_RESP);
    assign axil.r_valid  = (state == ST_R_RESP);
    assign axil.b_resp   = b_resp_q;
    assign axil.r_resp   = r_resp_q;
    assign axil.r_data   = r_data_q;

    assign pause_ack = (state == ST_PAUSED);
    assign mem_req   = ((state == ST_MEM_WR) || (state == ST_MEM_RD)) && in_range_q;
    assign mem_we    = (state == ST_MEM_WR) && in_range_q;

    // Out-of-range accesses still walk through the access state, just without a strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_PAUSED;
            rr_write   <= 1'b1;
            in_range_q <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            b_resp_q   <= RESP_OKAY;
            r_resp_q   <= RESP_OKAY;
            r_data_q   <= '0;
        end else begin
            case (state)
                ST_PAUSED: begin
                    if (!pause_req) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (pause_req) begin
                        state <= ST_PAUSED;
                    end else if (wr_grant) begin
                        mem_addr   <= axil.aw_addr[OFFSET +: MEM_ADDR_WIDTH];
                        mem_be     <= axil.w_strb;
                        mem_wdata  <= axil.w_data;
                        in_range_q <= wr_in_range;
                        b_resp_q   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                        state      <= ST_MEM_WR;
                    end else if (rd_grant) begin
                        mem_addr   <= axil.ar_addr[OFFSET +: MEM_ADDR_WIDTH];
                        mem_be     <= '1;
                        in_range_q <= rd_in_range;
                        r_resp_q   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                        state      <= ST_MEM_RD;
                    end
                    if (wr_elig && rd_elig) rr_write <= !rr_write;
                end
                ST_MEM_WR: state <= ST_B_RESP;
                ST_MEM_RD: state <= ST_RD_CAP;
                ST_RD_CAP: begin
                    r_data_q <= in_range_q ? mem_rdata : '0;
                    state    <= ST_R_RESP;
                end
                ST_B_RESP: begin
                    if (axil.b_ready) state <= ST_IDLE;
                end
                ST_R_RESP: begin
                    if (axil.r_ready) state <= ST_IDLE;
                end
                default: state <= ST_PAUSED;
            endcase
        end
    end

endmodule
